// File: rtl/mode_sel_fsm.sv
// Front-panel mode selector: debounced NEXT/PREV keys step a one-hot mode with wrap-around.
// Optional idle auto-return to mode 0 is built when MODE_TIMEOUT_EN is defined.
module mode_sel_fsm #(
    parameter int unsigned N_MODES     = 3,
    parameter int unsigned DEB_CYCLES  = 20000,
    parameter int unsigned IDLE_CYCLES = 50000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       key_next_n,
    input  logic                       key_prev_n,
    input  logic                       lock,
    output logic [N_MODES-1:0]         state,
    output logic [$clog2(N_MODES)-1:0] mode_idx,
    output logic                       mode_chg
);

    localparam int unsigned IW = $clog2(N_MODES);
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic {KEY_RELEASED, KEY_PRESSED} key_st_e;

    logic [1:0]         w_raw;
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         w_evt;
    logic [N_MODES-1:0] r_state;
    logic [N_MODES-1:0] w_state_nxt;
    logic [N_MODES-1:0] w_dec;
    logic [IW-1:0]      r_idx;
    logic [IW-1:0]      w_idx_nxt;
    logic               r_chg;
    logic               w_legal;
    logic               w_step_fwd;
    logic               w_step_bwd;
    logic               w_timeout;

    assign w_raw = {key_prev_n, key_next_n};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_deb
        key_st_e       r_st;
        key_st_e       w_st_nxt;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nxt;
        logic          r_armed;
        logic          w_armed_nxt;
        logic          r_evt;
        logic          w_evt_nxt;
        logic          w_lvl;

        assign w_lvl = r_sync2[k];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_st    <= KEY_RELEASED;
                r_cnt   <= '0;
                r_armed <= 1'b0;
                r_evt   <= 1'b0;
            end else begin
                r_st    <= w_st_nxt;
                r_cnt   <= w_cnt_nxt;
                r_armed <= w_armed_nxt;
                r_evt   <= w_evt_nxt;
            end
        end

        // After reset RELEASED is unarmed: a key held through reset must first be
        // seen released for DEB_CYCLES before a new press can be accepted.
        always_comb begin
            w_st_nxt    = r_st;
            w_cnt_nxt   = r_cnt;
            w_armed_nxt = r_armed;
            w_evt_nxt   = 1'b0;
            unique case (r_st)
                KEY_RELEASED: begin
                    if (r_armed ? !w_lvl : w_lvl) begin
                        if (r_cnt >= CW'(DEB_CYCLES - 1)) begin
                            w_cnt_nxt = '0;
                            if (r_armed) begin
                                w_st_nxt  = KEY_PRESSED;
                                w_evt_nxt = 1'b1;
                            end else begin
                                w_armed_nxt = 1'b1;
                            end
                        end else if (r_cnt != '1) begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                KEY_PRESSED: begin
                    if (w_lvl) begin
                        if (r_cnt >= CW'(DEB_CYCLES - 1)) begin
                            w_cnt_nxt = '0;
                            w_st_nxt  = KEY_RELEASED;
                        end else if (r_cnt != '1) begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_st_nxt  = KEY_RELEASED;
                    w_cnt_nxt = '0;
                end
            endcase
        end

        assign w_evt[k] = r_evt;
    end

    // Legal only if state is exactly the decode of an in-range index.
    always_comb begin
        w_dec = '0;
        for (int unsigned i = 0; i < N_MODES; i++) begin
            if (r_idx == IW'(i)) w_dec[i] = 1'b1;
        end
    end

    assign w_legal    = (r_state == w_dec) && (w_dec != '0);
    assign w_step_fwd = w_evt[0] & ~w_evt[1] & ~lock;
    assign w_step_bwd = w_evt[1] & ~w_evt[0] & ~lock;

`ifdef MODE_TIMEOUT_EN
    localparam int unsigned ICW = $clog2(IDLE_CYCLES + 1);

    logic [ICW-1:0] r_idle;

    assign w_timeout = (r_idx != '0) && (r_idle >= ICW'(IDLE_CYCLES - 1)) && !(|w_evt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if ((|w_evt) || w_timeout) begin
            r_idle <= '0;
        end else if ((r_idx != '0) && (r_idle != '1)) begin
            r_idle <= r_idle + ICW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_idx_nxt = r_idx;
        if (!w_legal) begin
            w_idx_nxt = '0;
        end else if (w_step_fwd) begin
            w_idx_nxt = (r_idx == IW'(N_MODES - 1)) ? '0 : r_idx + IW'(1);
        end else if (w_step_bwd) begin
            w_idx_nxt = (r_idx == '0) ? IW'(N_MODES - 1) : r_idx - IW'(1);
        end else if (w_timeout) begin
            w_idx_nxt = '0;
        end
        w_state_nxt = '0;
        for (int unsigned i = 0; i < N_MODES; i++) begin
            if (w_idx_nxt == IW'(i)) w_state_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= N_MODES'(1);
            r_idx   <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_chg   <= (w_idx_nxt != r_idx);
        end
    end

    assign state    = r_state;
    assign mode_idx = r_idx;
    assign mode_chg = r_chg;

endmodule

// File: tb/tb_mode_sel_fsm.sv
// Directed bench for mode_sel_fsm (N_MODES=3, DEB_CYCLES=4, IDLE_CYCLES=50).
// Timeout expectation follows MODE_TIMEOUT_EN.
module tb_mode_sel_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_next_n = 1'b1;
    logic       key_prev_n = 1'b1;
    logic       lock = 1'b0;
    logic [2:0] state;
    logic [1:0] mode_idx;
    logic       mode_chg;

    int n_vec = 0;
    int n_err = 0;
    int n_pulse = 0;
    bit mon_en = 1'b0;

    typedef struct {
        string      name;
        bit         nxt;
        bit         prv;
        bit         lck;
        int         hold;
        int         rel;
        logic [1:0] exp_idx;
        int         exp_pulses;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    mode_sel_fsm #(
        .N_MODES    (3),
        .DEB_CYCLES (4),
        .IDLE_CYCLES(50)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_next_n(key_next_n),
        .key_prev_n(key_prev_n),
        .lock      (lock),
        .state     (state),
        .mode_idx  (mode_idx),
        .mode_chg  (mode_chg)
    );

    always @(negedge clk) begin
        if (mode_chg === 1'b1) n_pulse++;
        if (mon_en && rst_n && (state !== (3'b001 << mode_idx))) begin
            n_err++;
            $display("FAIL onehot_agree: state=%b idx=%0d", state, mode_idx);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] es, input logic [1:0] ei, input logic ec);
        n_vec++;
        if (state !== es || mode_idx !== ei || mode_chg !== ec) begin
            n_err++;
            $display("FAIL %s: state=%b idx=%0d chg=%b, expected state=%b idx=%0d chg=%b",
                     name, state, mode_idx, mode_chg, es, ei, ec);
        end
    endtask

    task automatic chk_pulses(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s_pulses: got %0d pulses, expected %0d", name, got, exp);
        end
    endtask

    task automatic press(input bit nxt, input bit prv, input int hold, input int rel);
        key_next_n = ~nxt;
        key_prev_n = ~prv;
        cyc(hold);
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        cyc(rel);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         p0;
        logic [2:0] es;

        tbl[0] = '{"next1",       1'b1, 1'b0, 1'b0, 16, 10, 2'd1, 1};
        tbl[1] = '{"next2",       1'b1, 1'b0, 1'b0, 16, 10, 2'd2, 1};
        tbl[2] = '{"next_wrap",   1'b1, 1'b0, 1'b0, 16, 10, 2'd0, 1};
        tbl[3] = '{"prev_wrap",   1'b0, 1'b1, 1'b0, 16, 10, 2'd2, 1};
        tbl[4] = '{"prev_glitch", 1'b0, 1'b1, 1'b0,  3, 10, 2'd2, 0};
        tbl[5] = '{"both_keys",   1'b1, 1'b1, 1'b0, 16, 10, 2'd2, 0};
        tbl[6] = '{"lock_next",   1'b1, 1'b0, 1'b1, 16, 10, 2'd2, 0};
        tbl[7] = '{"prev_step",   0, 1'b1, 1'b0, 16, 10, 2'd1, 1};
        tbl[8] = '{"next_glitch", 1'b1, 1'b0, 1'b0,  3, 10, 2'd1, 0};
        tbl[9] = '{"lock_prev",   1'b0, 1'b1, 1'b1, 16, 10, 2'd1, 0};

        // reset
        cyc(2);
        rst_n = 1'b1;
        chk("reset", 3'b001, 2'd0, 1'b0);
        mon_en = 1'b1;
        cyc(10);

        foreach (tbl[i]) begin
            p0   = n_pulse;
            lock = tbl[i].lck;
            press(tbl[i].nxt, tbl[i].prv, tbl[i].hold, tbl[i].rel);
            lock = 1'b0;
            es   = 3'b001 << tbl[i].exp_idx;
            chk(tbl[i].name, es, tbl[i].exp_idx, 1'b0);
            chk_pulses(tbl[i].name, n_pulse - p0, tbl[i].exp_pulses);
        end

        // lock released while the key is still held: the press was consumed while locked
        p0 = n_pulse;
        lock = 1'b1;
        key_next_n = 1'b0;
        cyc(12);
        lock = 1'b0;
        cyc(12);
        key_next_n = 1'b1;
        cyc(10);
        chk("unlock_held", 3'b010, 2'd1, 1'b0);
        chk_pulses("unlock_held", n_pulse - p0, 0);

        // exact latency: 2 sync + 4 debounce + 1 = mode visible after 7th edge
        key_next_n = 1'b0;
        cyc(6);
        chk("lat_before", 3'b010, 2'd1, 1'b0);
        cyc(1);
        chk("lat_edge", 3'b100, 2'd2, 1'b1);
        cyc(1);
        chk("lat_after", 3'b100, 2'd2, 1'b0);
        cyc(8);
        key_next_n = 1'b1;
        cyc(10);

        // reset mid-press: held key must be released DEB cycles before it can fire
        p0 = n_pulse;
        key_prev_n = 1'b0;
        cyc(2);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        chk("rst_mid", 3'b001, 2'd0, 1'b0);
        cyc(30);
        chk("rst_held", 3'b001, 2'd0, 1'b0);
        key_prev_n = 1'b1;
        cyc(2);
        key_prev_n = 1'b0;
        cyc(20);
        chk("rst_short_rel", 3'b001, 2'd0, 1'b0);
        key_prev_n = 1'b1;
        cyc(10);
        chk_pulses("rst_mid", n_pulse - p0, 0);
        p0 = n_pulse;
        press(1'b0, 1'b1, 16, 10);
        chk("rst_refire", 3'b100, 2'd2, 1'b0);
        chk_pulses("rst_refire", n_pulse - p0, 1);

        // idle timeout
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        press(1'b1, 1'b0, 16, 10);
        key_next_n = 1'b0;
        cyc(7);
        chk("to_enter", 3'b100, 2'd2, 1'b1);
        cyc(9);
        key_next_n = 1'b1;
        cyc(40);
        chk("to_before", 3'b100, 2'd2, 1'b0);
        cyc(1);
`ifdef MODE_TIMEOUT_EN
        chk("to_fire", 3'b001, 2'd0, 1'b1);
        cyc(1);
        chk("to_after", 3'b001, 2'd0, 1'b0);
`else
        chk("to_hold", 3'b100, 2'd2, 1'b0);
        cyc(30);
        chk("to_hold_late", 3'b100, 2'd2, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
